mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 13, address width; DATA_W, default 8, data width; STARVE_LIMIT, default 16, max debug wait cycles.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 cpu_rd  input  1  CPU memory read request, from the CPU state machine.
REQ-004 cpu_wr  input  1  CPU memory write request.
REQ-005 cpu_addr  input  ADDR_W  CPU address.
REQ-006 cpu_wdata  input  DATA_W  CPU write data.
REQ-007 cpu_stall  output  1  CPU SHALL hold its current state while high.
REQ-008 dbg_req  input  1  debug/loader access request, held until dbg_ack.
REQ-009 dbg_we  input  1  debug access is a write (1) or a read (0); stable while dbg_req is high.
REQ-010 dbg_addr / dbg_wdata  input  ADDR_W / DATA_W  debug address and write data; stable while dbg_req is high.
REQ-011 dbg_ack  output  1  one-cycle completion pulse.
REQ-012 dbg_rdata  output  DATA_W  registered debug read data.
REQ-013 mem_rd / mem_wr  output  1 / 1  memory read and write strobes.
REQ-014 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, combinational, valid in the same cycle as mem_rd.
REQ-016 err_flag  output  1  sticky protocol-error flag.

Function
REQ-017 The state register SHALL hold one of three states: OWN_CPU, DBG_ACC, DBG_ACK.
REQ-018 In OWN_CPU and DBG_ACK, mem_rd/mem_wr/mem_addr/mem_wdata SHALL follow cpu_* combinationally, with zero added latency.
REQ-019 In DBG_ACC, mem_addr and mem_wdata SHALL be driven from dbg_addr and dbg_wdata, mem_wr SHALL equal dbg_we, mem_rd SHALL equal !dbg_we, and cpu_stall SHALL be 1.
REQ-020 cpu_stall SHALL be 0 in every state other than DBG_ACC; CPU strobes SHALL NOT reach memory in DBG_ACC.
REQ-021 OWN_CPU -> DBG_ACC SHALL occur when dbg_req=1 and cpu_rd=0 and cpu_wr=0, or on starvation (see REQ-029).
REQ-022 DBG_ACC -> DBG_ACK SHALL occur unconditionally after 1 cycle; on that edge dbg_rdata SHALL capture mem_rdata if dbg_we=0 and SHALL hold its value otherwise.
REQ-023 DBG_ACK -> OWN_CPU SHALL occur unconditionally; dbg_ack SHALL be 1 only in DBG_ACK.
REQ-024 dbg_req SHALL be ignored in DBG_ACC and DBG_ACK. A dbg_req still high in the first cycle of OWN_CPU SHALL start a new transaction.
REQ-025 Debug latency SHALL be: request seen in OWN_CPU with CPU idle -> dbg_ack 2 cycles later.
REQ-026 If cpu_rd=1 and cpu_wr=1 in the same cycle while the CPU owns the bus, mem_wr SHALL be forced 0, mem_rd SHALL pass through, and err_flag SHALL set on the next edge.
REQ-027 err_flag SHALL remain set until reset.

Reset
REQ-028 While rst_n=0, state SHALL be OWN_CPU and every output SHALL be 0, including the combinational mem_* outputs, which are gated by rst_n. Reset asserted during DBG_ACC or DBG_ACK SHALL abort the transaction without issuing dbg_ack.

Configuration
REQ-029 With MEM_ARB_STARVE_GUARD_EN defined:
- A counter of width clog2(STARVE_LIMIT+1) SHALL increment each OWN_CPU cycle in which dbg_req=1 and the CPU is busy.
- The counter SHALL clear whenever dbg_req=0 and on entry to DBG_ACC.
- When the counter equals STARVE_LIMIT, the next state SHALL be DBG_ACC regardless of CPU activity.
REQ-030 Without MEM_ARB_STARVE_GUARD_EN, no counter SHALL exist, and the debug requester SHALL wait indefinitely while the CPU is busy.

Verification
REQ-031 CPU read, cpu_rd=1, cpu_addr=0x0010, no dbg_req -> same cycle mem_rd=1, mem_addr=0x0010, cpu_stall=0.
REQ-032 Idle CPU, dbg_req=1, dbg_we=0, dbg_addr=0x1FFF, mem_rdata=0xA5 -> DBG_ACC next cycle with mem_rd=1 and cpu_stall=1; dbg_ack=1 and dbg_rdata=0xA5 the cycle after.
REQ-033 Debug write, dbg_we=1, dbg_addr=0x0004, dbg_wdata=0x3C, CPU asserts cpu_wr during DBG_ACC -> mem_wr=1, mem_wdata=0x3C, cpu_stall=1; the CPU write reaches memory only in DBG_ACK.
REQ-034 Guard defined, STARVE_LIMIT=16, CPU busy continuously, dbg_req=1 -> DBG_ACC entered after 16 counted cycles. Guard undefined -> no dbg_ack within 100 cycles.
REQ-035 cpu_rd=1 and cpu_wr=1 for 1 cycle -> mem_wr=0, err_flag=1 from the next cycle and persisting; rst_n pulse low -> err_flag=0.
REQ-036 rst_n asserted low in DBG_ACC -> dbg_ack never pulses, cpu_stall=0 immediately, and state is OWN_CPU after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// CPU / debug / memory bus bundle for mem_arbiter.
// slave = arbiter view, master = environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_flag;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output err_flag
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  err_flag
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/debug memory arbiter: CPU owns the bus, debug steals idle cycles.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_CPU,
    DBG_ACC,
    DBG_ACK
  } state_t;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  state_t state_q;
  state_t state_d;

  logic              cpu_busy;
  logic              starved;
  logic              rd_d;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              stall_d;
  logic              ack_d;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign cpu_busy = bus.cpu_rd | bus.cpu_wr;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // count cycles the debug requester waits behind a busy CPU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!bus.dbg_req) begin
      starve_q <= '0;
    end else if (state_q == OWN_CPU && state_d == DBG_ACC) begin
      starve_q <= '0;
    end else if (state_q == OWN_CPU && cpu_busy) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: debug waits for an idle CPU (or starvation)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OWN_CPU: begin
        if (bus.dbg_req && (!cpu_busy || starved)) begin
          state_d = DBG_ACC;
        end
      end
      DBG_ACC: state_d = DBG_ACK;
      DBG_ACK: state_d = OWN_CPU;
      default: state_d = OWN_CPU;
    endcase
  end

  // memory mux; everything forced low while in reset
  always_comb begin
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    stall_d = 1'b0;
    ack_d   = 1'b0;
    if (rst_n) begin
      if (state_q == DBG_ACC) begin
        rd_d    = !bus.dbg_we;
        wr_d    = bus.dbg_we;
        addr_d  = bus.dbg_addr;
        wdata_d = bus.dbg_wdata;
        stall_d = 1'b1;
      end else begin
        rd_d    = bus.cpu_rd;
        wr_d    = bus.cpu_wr & ~bus.cpu_rd;
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        ack_d   = (state_q == DBG_ACK);
      end
    end
  end

  // debug read data captured at the end of the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == DBG_ACC && !bus.dbg_we) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // sticky error on simultaneous CPU read and write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q != DBG_ACC && bus.cpu_rd && bus.cpu_wr) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_rd    = rd_d;
  assign bus.mem_wr    = wr_d;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.cpu_stall = stall_d;
  assign bus.dbg_ack   = ack_d;
  assign bus.dbg_rdata = rdata_q;
  assign bus.err_flag  = err_q;

endmodule
